// File: rtl/bit_serial_core_pkg.sv
// Shared types and opcode property masks for the bit-serial core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_serial_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDSW = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_ST   = 3'b110,
    OP_LDA  = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Opcode-indexed masks: bit n describes opcode n.
  // Ops that write the accumulator are exactly the ops that update the zero flag.
  localparam logic [7:0] OP_WRITES_ACC    = 8'b1011_1100;  // ADD SUB AND XOR LDA
  localparam logic [7:0] OP_UPDATES_CARRY = 8'b0000_1100;  // ADD SUB
  localparam logic [7:0] OP_WRITES_REG    = 8'b0100_0010;  // LDSW ST

endpackage

// File: rtl/bit_serial_core_if.sv
// Instruction/handshake bundle between fetch logic, switch/display I/O and the core.
// Latency: n/a (wiring only); master drives i_* signals, slave drives o_* signals.
// Backpressure: i_start is only honoured while o_busy is low; there is no queueing.
interface bit_serial_core_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int RA_W = $clog2(NREGS);

  logic                   i_start;
  logic [2:0]             i_opcode;
  logic [RA_W-1:0]        i_rd;
  logic [WIDTH-1:0]       i_data_switch;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_con_pcincr;
  logic                   o_carry;
  logic                   o_zero;
  logic [WIDTH-1:0]       o_acc;
  logic [NREGS*WIDTH-1:0] o_regs;

  modport master (
    output i_start, i_opcode, i_rd, i_data_switch,
    input  o_busy, o_done, o_con_pcincr, o_carry, o_zero, o_acc, o_regs
  );

  modport slave (
    input  i_start, i_opcode, i_rd, i_data_switch,
    output o_busy, o_done, o_con_pcincr, o_carry, o_zero, o_acc, o_regs
  );
endinterface

// File: rtl/bit_serial_core_alu.sv
// One-bit ALU slice: add/sub full adder, and, xor and operand pass-through.
// Latency: combinational.
// Backpressure: none.
// Ports: a (acc bit, or switch bit for LDSW), r (register bit), cin, opcode -> res, cout.
module bs_serial_alu
  import bit_serial_pkg::*;
(
  input  logic    a,
  input  logic    r,
  input  logic    cin,
  input  opcode_e opcode,
  output logic    res,
  output logic    cout
);

  logic rb;

  always_comb begin
    rb   = (opcode == OP_SUB) ? ~r : r;
    res  = a;
    cout = cin;
    unique case (opcode)
      OP_ADD, OP_SUB: begin
        res  = a ^ rb ^ cin;
        cout = (a & rb) | (a & cin) | (rb & cin);
      end
      OP_AND: res = a & r;
      OP_XOR: res = a ^ r;
      OP_LDA: res = r;
      // NOP, LDSW and ST pass 'a' straight through.
      default: res = a;
    endcase
  end

endmodule

// File: rtl/bit_serial_core.sv
// Bit-serial datapath: accumulator + NREGS GPRs, one result bit per clock, LSB first.
// Latency: start sampled at edge E, o_done/o_con_pcincr high for the cycle after edge E+WIDTH.
// Backpressure: i_start ignored while o_busy; accepted in the o_done cycle (back-to-back).
// Ports: i_clk, i_rst (sync, active-high), bus (slave side of bit_serial_core_if).
module bit_serial_core
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  bit_serial_core_if.slave   bus
);

  localparam int RA_W  = $clog2(NREGS);
  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  opcode_e            op_q, op_d;
  logic [RA_W-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0]   sw_q, sw_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;      // serial carry between bit slices
  logic               zacc_q, zacc_d;  // OR of result bits produced so far
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               last;
  logic               alu_a, alu_res, alu_cout;
  logic [WIDTH-1:0]   reg_sel;

  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign reg_sel = regs_q[rd_q];
  // LDSW routes the switch bit through the pass-through path of the slice.
  assign alu_a   = (op_q == OP_LDSW) ? sw_q[0] : acc_q[0];

  bs_serial_alu u_alu (
    .a      (alu_a),
    .r      (reg_sel[0]),
    .cin    (cy_q),
    .opcode (op_q),
    .res    (alu_res),
    .cout   (alu_cout)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.i_start) state_d = EXEC;
      EXEC: if (last)        state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.o_busy       = (state_q == EXEC);
    bus.o_done       = done_q;
    bus.o_con_pcincr = done_q;
    bus.o_carry      = carry_q;
    bus.o_zero       = zero_q;
    bus.o_acc        = acc_q;
    bus.o_regs       = '0;
    for (int k = 0; k < NREGS; k++) bus.o_regs[k*WIDTH +: WIDTH] = regs_q[k];
  end

  // Datapath next state
  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    sw_d    = sw_q;
    acc_d   = acc_q;
    regs_d  = regs_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (bus.i_start) begin
        op_d   = opcode_e'(bus.i_opcode);
        rd_d   = bus.i_rd;
        sw_d   = bus.i_data_switch;
        cnt_d  = '0;
        // SUB is a + ~r + 1: the +1 enters as the initial carry.
        cy_d   = (opcode_e'(bus.i_opcode) == OP_SUB);
        zacc_d = 1'b0;
      end
    end else begin
      // Destinations take the result bit at the MSB; the other operand rotates
      // its LSB back in, so it is restored after exactly WIDTH shifts.
      acc_d = {OP_WRITES_ACC[op_q] ? alu_res : acc_q[0], acc_q[WIDTH-1:1]};
      regs_d[rd_q] = {OP_WRITES_REG[op_q] ? alu_res : reg_sel[0], reg_sel[WIDTH-1:1]};
      sw_d   = {sw_q[0], sw_q[WIDTH-1:1]};
      cy_d   = alu_cout;
      zacc_d = zacc_q | alu_res;
      cnt_d  = cnt_q + CNT_W'(1);
      if (last) begin
        done_d = 1'b1;
        if (OP_UPDATES_CARRY[op_q]) carry_d = alu_cout;
        // Fold in the final bit here so no extra pass is needed.
        if (OP_WRITES_ACC[op_q])    zero_d  = ~(zacc_q | alu_res);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q    <= OP_NOP;
      rd_q    <= '0;
      sw_q    <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      rd_q    <= rd_d;
      sw_q    <= sw_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_serial_core.sv
// Randomised + directed bench for bit_serial_core at 8x4 and 16x8 against an arithmetic model.
// Latency: checks done at exactly WIDTH edges after the start edge.
// Backpressure: exercises start-while-busy (ignored) and start-in-done-cycle (accepted).
module tb_bit_serial_core;

  localparam logic [2:0] NOP = 3'd0, LDSW = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, XOR_ = 3'd5, ST = 3'd6, LDA = 3'd7;

  logic clk = 1'b0;
  logic rst8, rst16;
  always #5 clk = ~clk;

  bit_serial_core_if #(.WIDTH(8),  .NREGS(4)) b8  ();
  bit_serial_core_if #(.WIDTH(16), .NREGS(8)) b16 ();

  bit_serial_core #(.WIDTH(8),  .NREGS(4)) dut8  (.i_clk(clk), .i_rst(rst8),  .bus(b8));
  bit_serial_core #(.WIDTH(16), .NREGS(8)) dut16 (.i_clk(clk), .i_rst(rst16), .bus(b16));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, per DUT (0 = 8-bit, 1 = 16-bit)
  int unsigned m_acc [2];
  int unsigned m_reg [2][8];
  bit          m_c   [2];
  bit          m_z   [2];
  int          W_OF  [2] = '{8, 16};
  int          NR    [2] = '{4, 8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_acc(int d);
    return (d == 0) ? 32'(b8.o_acc) : 32'(b16.o_acc);
  endfunction
  function automatic logic [31:0] get_reg(int d, int k);
    return (d == 0) ? 32'(b8.o_regs[k*8 +: 8]) : 32'(b16.o_regs[k*16 +: 16]);
  endfunction
  function automatic logic get_busy(int d);  return (d == 0) ? b8.o_busy : b16.o_busy; endfunction
  function automatic logic get_done(int d);  return (d == 0) ? b8.o_done : b16.o_done; endfunction
  function automatic logic get_pc(int d);    return (d == 0) ? b8.o_con_pcincr : b16.o_con_pcincr; endfunction
  function automatic logic get_carry(int d); return (d == 0) ? b8.o_carry : b16.o_carry; endfunction
  function automatic logic get_zero(int d);  return (d == 0) ? b8.o_zero : b16.o_zero; endfunction

  task automatic drive(input int d, input logic s, input logic [2:0] op, input int rd,
                       input logic [15:0] sw);
    if (d == 0) begin
      b8.i_start = s; b8.i_opcode = op; b8.i_rd = 2'(rd); b8.i_data_switch = sw[7:0];
    end else begin
      b16.i_start = s; b16.i_opcode = op; b16.i_rd = 3'(rd); b16.i_data_switch = sw;
    end
  endtask

  task automatic model_exec(input int d, input logic [2:0] op, input int rd, input logic [15:0] sw);
    int unsigned mask, a, r, s;
    mask = (W_OF[d] == 16) ? 32'hFFFF : 32'hFF;
    a = m_acc[d];
    r = m_reg[d][rd];
    case (op)
      LDSW: m_reg[d][rd] = 32'(sw) & mask;
      ADD, SUB: begin
        s = (op == ADD) ? a + r : a + ((~r) & mask) + 1;
        m_acc[d] = s & mask;
        m_c[d]   = ((s >> W_OF[d]) & 1) != 0;
        m_z[d]   = (m_acc[d] == 0);
      end
      AND_: begin m_acc[d] = a & r; m_z[d] = (m_acc[d] == 0); end
      XOR_: begin m_acc[d] = a ^ r; m_z[d] = (m_acc[d] == 0); end
      ST:   m_reg[d][rd] = a;
      LDA:  begin m_acc[d] = r; m_z[d] = (m_acc[d] == 0); end
      default: ;
    endcase
  endtask

  task automatic model_clear(input int d);
    m_acc[d] = 0; m_c[d] = 0; m_z[d] = 0;
    for (int k = 0; k < 8; k++) m_reg[d][k] = 0;
  endtask

  task automatic check_state(input int d, input string pfx);
    check({pfx, "_acc"},   get_acc(d),   m_acc[d]);
    check({pfx, "_carry"}, get_carry(d), 32'(m_c[d]));
    check({pfx, "_zero"},  get_zero(d),  32'(m_z[d]));
    for (int k = 0; k < NR[d]; k++)
      check($sformatf("%s_reg%0d", pfx, k), get_reg(d, k), m_reg[d][k]);
  endtask

  task automatic do_reset(input int d);
    if (d == 0) rst8 = 1'b1; else rst16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (d == 0) rst8 = 1'b0; else rst16 = 1'b0;
    model_clear(d);
    check("rst_busy", 32'(get_busy(d)), 0);
    check("rst_done", 32'(get_done(d)), 0);
    check_state(d, "rst");
  endtask

  // Entered and left at a negedge; leaves in the done cycle so a following
  // call starts back-to-back.
  task automatic run(input int d, input logic [2:0] op, input int rd, input logic [15:0] sw,
                     input bit noisy);
    int k, bc, w;
    w = W_OF[d];
    drive(d, 1'b1, op, rd, sw);
    @(posedge clk);
    @(negedge clk);
    bc = get_busy(d) ? 1 : 0;
    k  = 0;
    drive(d, noisy, 3'($urandom_range(7)), $urandom_range(NR[d] - 1), 16'($urandom));
    for (int guard = 0; guard < 3 * w; guard++) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (get_busy(d)) bc++;
      if (get_done(d)) break;
      drive(d, noisy, 3'($urandom_range(7)), $urandom_range(NR[d] - 1), 16'($urandom));
    end
    drive(d, 1'b0, NOP, 0, 16'h0);
    check("done_latency", k, w);
    check("busy_cycles", bc, w);
    check("pcincr", 32'(get_pc(d)), 1);
    model_exec(d, op, rd, sw);
    check_state(d, "exec");
  endtask

  task automatic idle_one(input int d);
    @(posedge clk);
    @(negedge clk);
    check("idle_done_low", {30'd0, get_done(d), get_busy(d)}, 0);
  endtask

  initial begin
    int dsel, ndone;
    rst8 = 1'b0;
    rst16 = 1'b0;
    drive(0, 1'b0, NOP, 0, 16'h0);
    drive(1, 1'b0, NOP, 0, 16'h0);
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // First transaction latency and placement
    run(0, LDSW, 2, 16'h00A5, 1'b0);
    check("ldsw_reg2_const", get_reg(0, 2), 32'hA5);
    idle_one(0);

    // Arithmetic flags
    run(0, LDSW, 0, 16'h00C8, 1'b0);
    run(0, LDA,  0, 16'h0, 1'b0);
    run(0, ADD,  0, 16'h0, 1'b0);
    check("add_const", get_acc(0), 32'h90);
    run(0, SUB,  0, 16'h0, 1'b0);
    check("sub_borrow_const", {get_acc(0)[30:0], get_carry(0)}, {31'hC8, 1'b0});
    run(0, ST,   1, 16'h0, 1'b0);
    run(0, SUB,  1, 16'h0, 1'b0);

    // Logic ops; carry must survive AND/XOR
    run(0, LDSW, 1, 16'h00F0, 1'b0);
    run(0, LDA,  1, 16'h0, 1'b0);
    run(0, LDSW, 2, 16'h003C, 1'b0);
    run(0, AND_, 2, 16'h0, 1'b0);
    run(0, LDSW, 3, 16'h0030, 1'b0);
    run(0, XOR_, 3, 16'h0, 1'b0);

    // Store keeps the source intact
    run(0, LDSW, 1, 16'h005A, 1'b0);
    run(0, LDA,  1, 16'h0, 1'b0);
    run(0, ST,   3, 16'h0, 1'b0);
    idle_one(0);

    // Start pulsed throughout EXEC is ignored; then back-to-back pair
    run(0, ADD, 2, 16'h0, 1'b1);
    idle_one(0);
    run(0, XOR_, 0, 16'h0, 1'b0);
    run(0, NOP,  1, 16'hFFFF, 1'b0);

    // Reset at shift cycle 4 of an ADD
    drive(0, 1'b1, ADD, 1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, NOP, 0, 16'h0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    model_clear(0);
    check("midrst_busy", 32'(get_busy(0)), 0);
    check("midrst_done", 32'(get_done(0)), 0);
    check_state(0, "midrst");
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(0)) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // Wider instance: wrap-around add
    run(1, LDSW, 0, 16'hFFFF, 1'b0);
    run(1, LDSW, 5, 16'h0001, 1'b0);
    run(1, LDA,  0, 16'h0, 1'b0);
    run(1, ADD,  5, 16'h0, 1'b0);
    check("w16_wrap_const", {get_acc(1)[29:0], get_carry(1), get_zero(1)}, 32'h3);

    // Random traffic on both widths
    for (int i = 0; i < 80; i++) begin
      dsel = $urandom_range(1);
      run(dsel, 3'($urandom_range(7)), $urandom_range(NR[dsel] - 1), 16'($urandom),
          ($urandom_range(3) == 0));
      if ($urandom_range(3) == 0) idle_one(dsel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
